// File: rtl/vga_pkg.sv
// Shared VGA timing types, default 640x480@60 timing constants and decode helpers.
// Imported by the timing generator and by the downstream pixel colour stage.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_CLK_DIV  = 2;

    typedef logic [9:0] vga_coord_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
        logic line_start;
        logic frame_start;
    } vga_timing_t;

    // Half-open window test lo <= c < hi; int math keeps hi = 1024 representable.
    function automatic logic in_range(input vga_coord_t c, input int lo, input int hi);
        return (int'(c) >= lo) && (int'(c) < hi);
    endfunction

endpackage

// File: rtl/clk_en_div.sv
// Registered clock-enable divider: en is high for one clk out of every DIV.
// DIV = 1 holds en high on every clk once out of reset.
module clk_en_div #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic en
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    if (DIV < 1) begin : g_bad_div
        $error("clk_en_div: DIV must be at least 1");
    end

    logic [W-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt <= '0;
            en      <= 1'b0;
        end else begin
            en <= (div_cnt == LAST);
            if (div_cnt == LAST) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel strobe, horizontal/vertical counters and a Moore
// decode of sync, active video and line/frame start pulses.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = VGA_CLK_DIV,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam vga_coord_t H_LAST = vga_coord_t'(H_TOTAL - 1);
    localparam vga_coord_t V_LAST = vga_coord_t'(V_TOTAL - 1);

    if (H_TOTAL > 1024) begin : g_bad_h
        $error("vga_timing_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_bad_v
        $error("vga_timing_gen: V_TOTAL exceeds 1024");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end

    vga_coord_t  h_cnt;
    vga_coord_t  v_cnt;
    vga_timing_t timing;

    clk_en_div #(
        .DIV(CLK_DIV)
    ) u_div (
        .clk(clk),
        .rst(rst),
        .en (pix_en)
    );

    // Reset parks the counters on the last pixel of the frame, so the first
    // strobe after release lands on (0,0) and the first frame is complete.
    always_ff @(posedge clk) begin
        if (!rst) begin
            h_cnt <= H_LAST;
            v_cnt <= V_LAST;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        timing             = '0;
        timing.hsync       = in_range(h_cnt, H_SYNC_START, H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        timing.vsync       = in_range(v_cnt, V_SYNC_START, V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        timing.active      = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
        timing.line_start  = pix_en && (h_cnt == '0);
        timing.frame_start = pix_en && (h_cnt == '0) && (v_cnt == '0);
    end

    assign x           = h_cnt;
    assign y           = v_cnt;
    assign hsync       = timing.hsync;
    assign vsync       = timing.vsync;
    assign active      = timing.active;
    assign line_start  = timing.line_start;
    assign frame_start = timing.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a tiny-frame CLK_DIV=1
// instance, each checked every clk against a closed-form timing model.
module tb_vga_timing_gen;
    localparam int W = 26;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    logic pix_en_a, hsync_a, vsync_a, active_a, line_start_a, frame_start_a;
    logic [9:0] x_a, y_a;
    logic pix_en_b, hsync_b, vsync_b, active_b, line_start_b, frame_start_b;
    logic [9:0] x_b, y_b;

    vga_timing_gen dut_a (
        .clk(clk), .rst(rst_a), .pix_en(pix_en_a), .x(x_a), .y(y_a),
        .hsync(hsync_a), .vsync(vsync_a), .active(active_a),
        .line_start(line_start_a), .frame_start(frame_start_a)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst_b), .pix_en(pix_en_b), .x(x_b), .y(y_b),
        .hsync(hsync_b), .vsync(vsync_b), .active(active_b),
        .line_start(line_start_b), .frame_start(frame_start_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Closed-form model: n = clk edges with rst high since the last reset edge.
    function automatic logic [W-1:0] model(input int n, input int div,
                                           input int ha, input int hf, input int hs, input int hb,
                                           input int va, input int vf, input int vs, input int vb);
        int ht, vt, adv, p, h, v;
        logic en, hsy, vsy, act;
        ht  = ha + hf + hs + hb;
        vt  = va + vf + vs + vb;
        en  = (n > 0) && ((n % div) == 0);
        adv = (n > 0) ? (n - 1) / div : 0;
        p   = adv - 1;
        if (p < 0) begin
            h = ht - 1;
            v = vt - 1;
        end else begin
            h = p % ht;
            v = (p / ht) % vt;
        end
        hsy = !((h >= ha + hf) && (h < ha + hf + hs));
        vsy = !((v >= va + vf) && (v < va + vf + vs));
        act = (h < ha) && (v < va);
        return {en, 10'(h), 10'(v), hsy, vsy, act, en && (h == 0), en && (h == 0) && (v == 0)};
    endfunction

    logic [W-1:0] exp_a_q[$];
    logic [W-1:0] exp_b_q[$];
    int n_a = 0;
    int n_b = 0;

    always @(posedge clk) begin
        n_a = rst_a ? n_a + 1 : 0;
        n_b = rst_b ? n_b + 1 : 0;
        exp_a_q.push_back(model(n_a, 2, 640, 16, 96, 48, 480, 10, 2, 33));
        exp_b_q.push_back(model(n_b, 1, 8, 2, 3, 3, 6, 1, 2, 2));
    end

    always @(negedge clk) begin
        if (exp_a_q.size() > 0)
            check("a_cycle", 32'({pix_en_a, x_a, y_a, hsync_a, vsync_a, active_a, line_start_a, frame_start_a}),
                  32'(exp_a_q.pop_front()));
        if (exp_b_q.size() > 0)
            check("b_cycle", 32'({pix_en_b, x_b, y_b, hsync_b, vsync_b, active_b, line_start_b, frame_start_b}),
                  32'(exp_b_q.pop_front()));
    end

    initial begin
        int first_pe, hs_low, hs_min, hs_max, pc, last_fs, fs_seen, act_cnt, vs_min, vs_max, pe_cnt;
        bit seen_fs, seen_wrap, done, seen_bwrap;
        logic [9:0] prev_x, prev_y;

        repeat (3) @(negedge clk);
        check("a_rst_x", 32'(x_a), 799);
        check("a_rst_y", 32'(y_a), 524);
        check("a_rst_sync", 32'({hsync_a, vsync_a}), 3);
        check("a_rst_flags", 32'({pix_en_a, active_a, line_start_a, frame_start_a}), 0);
        rst_a = 1'b1;
        rst_b = 1'b1;

        first_pe = -1; hs_low = 0; hs_min = 1023; hs_max = 0;
        seen_fs = 0; seen_wrap = 0; done = 0; prev_x = '0; prev_y = '0;
        for (int i = 1; i <= 5000 && !done; i++) begin
            @(negedge clk);
            if (pix_en_a && first_pe < 0) first_pe = i;
            if (pix_en_a) begin
                if (x_a == 0 && y_a == 0 && !seen_fs) begin
                    seen_fs = 1;
                    check("a_first_pe_idx", 32'(first_pe), 2);
                    check("a_first_pixel", 32'({frame_start_a, line_start_a, active_a}), 7);
                end
                if (y_a == 0) begin
                    if (!hsync_a) begin
                        hs_low++;
                        if (int'(x_a) < hs_min) hs_min = int'(x_a);
                        if (int'(x_a) > hs_max) hs_max = int'(x_a);
                    end
                    if (x_a == 655) check("a_hsync_655", 32'(hsync_a), 1);
                    if (x_a == 752) check("a_hsync_752", 32'(hsync_a), 1);
                    if (x_a == 640) check("a_active_x640", 32'(active_a), 0);
                end
                if (x_a == 0 && y_a == 1) begin
                    seen_wrap = 1;
                    check("a_wrap_prev", 32'({prev_x, prev_y}), 32'({10'd799, 10'd0}));
                    check("a_wrap_pulses", 32'({line_start_a, frame_start_a}), 2);
                end
                prev_x = x_a;
                prev_y = y_a;
                if (x_a == 300 && y_a == 1) done = 1;
            end
        end
        check("a_seen_first_frame", 32'(seen_fs), 1);
        check("a_seen_line_wrap", 32'(seen_wrap), 1);
        check("a_reached_x300", 32'(done), 1);
        check("a_hsync_low_count", 32'(hs_low), 96);
        check("a_hsync_low_min", 32'(hs_min), 656);
        check("a_hsync_low_max", 32'(hs_max), 751);

        rst_a = 1'b0;
        @(negedge clk);
        check("a_midrst_xy", 32'({x_a, y_a}), 32'({10'd799, 10'd524}));
        check("a_midrst_flags", 32'({pix_en_a, hsync_a, vsync_a, active_a}), 32'(4'b0110));
        rst_a = 1'b1;
        first_pe = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (pix_en_a && first_pe < 0) begin
                first_pe = i;
                check("a_restart_pe_x", 32'(x_a), 799);
            end
        end
        check("a_restart_pe_idx", 32'(first_pe), 2);

        pc = 0; last_fs = 0; fs_seen = 0; act_cnt = 0; vs_min = 1023; vs_max = 0;
        seen_bwrap = 0; prev_x = '0; prev_y = '0;
        for (int i = 0; i < 800 && fs_seen < 3; i++) begin
            @(negedge clk);
            if (pix_en_b) begin
                pc++;
                if (frame_start_b) begin
                    if (fs_seen >= 1) begin
                        check("b_frame_period", 32'(pc - last_fs), 176);
                        check("b_active_count", 32'(act_cnt), 48);
                    end
                    last_fs = pc;
                    fs_seen++;
                    act_cnt = 0;
                end
                if (active_b) act_cnt++;
                if (!vsync_b) begin
                    if (int'(y_b) < vs_min) vs_min = int'(y_b);
                    if (int'(y_b) > vs_max) vs_max = int'(y_b);
                end
                if (x_b == 0 && y_b == 0 && prev_x == 15 && prev_y == 10) seen_bwrap = 1;
                if (x_b == 0 && y_b == 6) check("b_active_y6", 32'(active_b), 0);
                prev_x = x_b;
                prev_y = y_b;
            end
        end
        check("b_frames_seen", 32'(fs_seen), 3);
        check("b_vsync_low_min", 32'(vs_min), 7);
        check("b_vsync_low_max", 32'(vs_max), 8);
        check("b_frame_wrap", 32'(seen_bwrap), 1);

        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (pix_en_b && x_b == 5 && y_b == 3) done = 1;
        end
        check("b_reached_mid", 32'(done), 1);
        rst_b = 1'b0;
        @(negedge clk);
        check("b_midrst_xy", 32'({x_b, y_b}), 32'({10'd15, 10'd10}));
        check("b_midrst_flags", 32'({pix_en_b, hsync_b, vsync_b}), 32'(3'b011));
        rst_b = 1'b1;
        pe_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pix_en_b) pe_cnt++;
        end
        check("b_pe_every_clk", 32'(pe_cnt), 20);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
